spart_tx: RTL and testbench
===========================

Name: spart_tx

Overview:
- Transmit end of the SPART send interface.
- Accepts bytes pushed by the processor core on send/send_data.
- Buffers them in a small FIFO and signals back-pressure through full.
- Serializes each byte onto txd as an asynchronous 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the core's EX-stage SPART outputs and the board-level TX pin.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- BAUD_DIV, 16'd434: clocks per bit time; minimum 2.
- CNT_W, 16: width of the baud counter; must hold BAUD_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- send  input  1  push strobe; one byte per cycle while high
- send_data  input  8  byte to push, sampled when send=1
- full  output  1  FIFO holds DEPTH entries; push is ignored
- txd  output  1  serial line; idles high
- tx_busy  output  1  high when FSM is not IDLE or FIFO is non-empty
- tx_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - txd=1, full=0, tx_busy=0, tx_count=0.
  - FSM=IDLE, baud counter=0, bit index=0, FIFO read/write pointers=0.
  - rst mid-frame aborts the frame; txd returns to 1 on the next edge and queued bytes are discarded.
- FIFO:
  - Write when send & ~full. Read (pop) when FSM in IDLE & count!=0, or at end of STOP & count!=0.
  - full = (count==DEPTH), combinational from the registered count.
  - send while full: byte dropped, no state change. This holds even if a pop happens in the same cycle; full is evaluated before the pop. The core is required to stall on full.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Baud counter:
  - Reset to 0 on any state transition.
  - Otherwise increments; bit_done asserts when counter==BAUD_DIV-1.
  - Each serial bit therefore lasts exactly BAUD_DIV clocks.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count!=0, pop into shift register and go to START.
  - START: txd=0. On bit_done, go to DATA with bit index=0.
  - DATA: txd=shift[0]. On bit_done, shift right and increment index; after index 7, go to STOP.
  - STOP: txd=1. On bit_done, go to START with a pop if count!=0, else IDLE. There is no idle gap between back-to-back frames.
- txd is driven from a register (glitch-free).
- Latency: send sampled at edge N → FIFO count=1 after N → pop and enter START at edge N+1. txd is low from edge N+1 until edge N+1+BAUD_DIV.
- Frame length: 10*BAUD_DIV clocks. Back-to-back frames occur every 10*BAUD_DIV clocks.
- tx_busy drops to 0 in the same cycle the FSM re-enters IDLE with an empty FIFO.

Optional Feature:
- Macro: SPART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits), held for BAUD_DIV clocks.
  - Frame becomes 11*BAUD_DIV clocks (8E1).
- Undefined: no PARITY state; 8N1 frame of 10*BAUD_DIV clocks.

Decomposition:
- Shared package spart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP/PARITY).
  - Constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1.
  - The same enum and constants are reused by the receive side.
- Sub-module spart_tx_fifo:
  - Parameter DEPTH.
  - Ports: clk, rst, wr, wdata, rd, rdata, count, full, empty.
  - Top level holds the FSM, baud counter and shift register.

Test Plan:
- BAUD_DIV=4, single push of 0xA5 at edge 0 → txd low from edge 1. Bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 clocks. tx_busy falls at edge 41.
- DEPTH=4, push 0x01..0x06 on 6 consecutive cycles → byte 0x01 is popped at edge 1. full=1 after edge 4. 0x06 is dropped. Exactly bytes 0x01..0x05 are transmitted back-to-back with no idle clocks between stop and next start.
- Simultaneous push and pop at the STOP→START boundary with count=2 → count stays 2 and frame order is preserved.
- Assert rst for 1 cycle mid-DATA of 0x3C with 2 bytes queued → txd=1 next edge, tx_count=0, tx_busy=0, and no further frames.
- SPART_TX_PARITY_EN defined, push 0x07 → 11-bit frame with parity bit=1. Push 0x03 → parity bit=0.
- Push while full in the same cycle as a STOP-end pop → byte dropped; count goes from DEPTH to DEPTH-1.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit and receive sides:
// line-state encoding, frame constants and a parity helper.
package spart_pkg;

    // Serial FSM states; PARITY is only reachable when parity framing is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } spart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Small byte FIFO in front of the SPART serializer.
// The head entry is read combinationally so the serializer can load it
// on the same edge that pops it.
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic                   rd,
    output logic [DATA_BITS-1:0]   rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 do_wr;
    logic                 do_rd;

    // full/empty come from the registered count, so a push while full is
    // rejected even if a pop happens in the same cycle.
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;
    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

    // Storage write; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: byte FIFO plus asynchronous serializer.
// Default frame is 8N1 (10 bit times). Defining SPART_TX_PARITY_EN inserts
// an even-parity bit before the stop bit, giving 8E1 (11 bit times).
// Back-to-back frames are sent with no idle gap between stop and next start.
module spart_tx
    import spart_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] BAUD_DIV = 16'd434,
    parameter int          CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   send,
    input  logic [7:0]             send_data,
    output logic                   full,
    output logic                   txd,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] tx_count
);

    spart_state_e         state_reg;
    logic [CNT_W-1:0]     baud_cnt_reg;
    logic [2:0]           bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 txd_reg;
`ifdef SPART_TX_PARITY_EN
    logic                 parity_reg;
`endif

    logic                 bit_done;
    logic                 fifo_rd;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [$clog2(DEPTH):0] fifo_count;

    assign bit_done = (baud_cnt_reg == CNT_W'(BAUD_DIV - 16'd1));

    // The FIFO only pops when it is non-empty, matching the FSM load points.
    assign fifo_rd = (state_reg == IDLE) || ((state_reg == STOP) && bit_done);

    spart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (send),
        .wdata (send_data),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign full     = fifo_full;
    assign tx_count = fifo_count;
    assign txd      = txd_reg;
    assign tx_busy  = (state_reg != IDLE) || !fifo_empty;

    // Serializer FSM: txd is registered and set together with each state
    // change, so every bit level holds for exactly BAUD_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= IDLE_LEVEL;
`ifdef SPART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    txd_reg      <= IDLE_LEVEL;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_rdata;
`ifdef SPART_TX_PARITY_EN
                        parity_reg <= even_parity(fifo_rdata);
`endif
                        state_reg <= START;
                        txd_reg   <= START_LEVEL;
                    end
                end

                START: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA;
                        txd_reg      <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= shift_reg >> 1;
                        bit_idx_reg  <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef SPART_TX_PARITY_EN
                            state_reg <= PARITY;
                            txd_reg   <= parity_reg;
`else
                            state_reg <= STOP;
                            txd_reg   <= STOP_LEVEL;
`endif
                        end else begin
                            // Next bit is the one about to shift into position 0.
                            txd_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

`ifdef SPART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= STOP;
                        txd_reg      <= STOP_LEVEL;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        baud_cnt_reg <= '0;
                        if (!fifo_empty) begin
                            // Chain straight into the next frame, no idle gap.
                            shift_reg <= fifo_rdata;
`ifdef SPART_TX_PARITY_EN
                            parity_reg <= even_parity(fifo_rdata);
`endif
                            state_reg <= START;
                            txd_reg   <= START_LEVEL;
                        end else begin
                            state_reg <= IDLE;
                            txd_reg   <= IDLE_LEVEL;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    baud_cnt_reg <= '0;
                    txd_reg      <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx with DEPTH=4, BAUD_DIV=4. A frame-level reference
// model (queue of pending bytes plus the start edge of the frame on the
// line) predicts txd, tx_count, full and tx_busy after every clock edge.
module tb_spart_tx;

    localparam int DEPTH = 4;
    localparam int BAUD  = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [7:0] send_data;
    logic       full;
    logic       txd;
    logic       tx_busy;
    logic [2:0] tx_count;

    always #5 clk = ~clk;

    spart_tx #(
        .DEPTH    (DEPTH),
        .BAUD_DIV (16'(BAUD)),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .send_data (send_data),
        .full      (full),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .tx_count  (tx_count)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         active   = 1'b0;
    int         fr_start = 0;
    int         fr_end   = 0;
    logic [7:0] fr_byte  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected line level from frame position: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_txd();
        int k;
        if (!active) return 1'b1;
        k = (cyc - fr_start) / BAUD;
        if (k == 0) return 1'b0;
        if (k <= 8) return fr_byte[k-1];
`ifdef SPART_TX_PARITY_EN
        if (k == 9) return ^fr_byte;
`endif
        return 1'b1;
    endfunction

    // Drive inputs, take one clock edge, advance the model, check outputs.
    task automatic step(input logic s, input logic [7:0] d, input logic r);
        bit full_before;
        send      = s;
        send_data = d;
        rst       = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            mq.delete();
            active = 1'b0;
        end else begin
            full_before = (mq.size() == DEPTH);
            if (active && cyc == fr_end) active = 1'b0;
            if (mq.size() > 0 && !active) begin
                fr_byte  = mq.pop_front();
                fr_start = cyc;
                fr_end   = cyc + FL;
                active   = 1'b1;
            end
            if (s && !full_before) mq.push_back(d);
        end
        #1;
        chk("txd",      32'(txd),      32'(exp_txd()));
        chk("tx_count", 32'(tx_count), 32'(mq.size()));
        chk("full",     32'(full),     32'(mq.size() == DEPTH));
        chk("tx_busy",  32'(tx_busy),  32'(active || mq.size() > 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Idle until the next edge ends the current frame (bounded).
    task automatic wait_frame_end();
        int n = 0;
        while (!(active && cyc + 1 == fr_end) && n < 4 * FL) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("frame_end_reached", 32'(active && cyc + 1 == fr_end), 32'd1);
    endtask

    initial begin
        send      = 1'b0;
        send_data = 8'h00;
        rst       = 1'b1;

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Single byte 0xA5
        step(1'b1, 8'hA5, 1'b0);
        run(FL + 8);

        // Six consecutive pushes into a 4-deep FIFO: 0x06 is dropped
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
        run(5 * FL + 10);

        // Push coinciding with the STOP->START pop while two bytes wait
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        wait_frame_end();
        step(1'b1, 8'($urandom), 1'b0);
        chk("boundary_count", 32'(tx_count), 32'd2);
        run(4 * FL + 10);

        // Fill to full, then push on the STOP-end pop edge: dropped
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        wait_frame_end();
        step(1'b1, 8'($urandom), 1'b0);
        chk("drop_on_pop_count", 32'(tx_count), 32'(DEPTH - 1));
        run(5 * FL + 10);

        // Reset in the middle of DATA of 0x3C with two bytes queued
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        begin
            int n = 0;
            while (!(active && cyc - fr_start == 3 * BAUD + 1) && n < FL) begin
                step(1'b0, 8'h00, 1'b0);
                n++;
            end
        end
        chk("mid_data_reached", 32'(active && cyc - fr_start == 3 * BAUD + 1), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        run(FL + 5);

        // Parity-sensitive bytes
        step(1'b1, 8'h07, 1'b0);
        run(FL + 4);
        step(1'b1, 8'h03, 1'b0);
        run(FL + 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
        end
        run(6 * FL + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
